// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter and its helpers.
// Contents:
//   FRAME_LEN / LAST_IDX  length of one ASCII frame and index of its final byte
//   ASCII_CR / ASCII_LF   line terminator bytes appended to every frame
//   TAG_BASE              ASCII 'A', the tag of requester 0
//   arb_state_t           arbiter state encoding
//   nib2hex()             4-bit nibble to upper-case ASCII hex digit
package uart_arb_pkg;

  localparam int         FRAME_LEN = 7;
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] TAG_BASE  = 8'h41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // 0-9 land on '0'-'9' (0x30 base); A-F land on 'A'-'F', which is 0x37 + nibble.
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Searches the request vector starting one position after the previous
// winner and wrapping around, so the previous winner has lowest priority.
// Ports:
//   i_req         request vector, one bit per requester
//   i_last_grant  index of the previous winner
//   o_valid       at least one request is present
//   o_idx         winning index (meaningful only when o_valid is high)
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_last_grant,
  output logic               o_valid,
  output logic [1:0]         o_idx
);

  // Walk the NUM_REQ candidates in priority order; the first hit wins and
  // later hits are masked by o_valid. last_grant < NUM_REQ, so a single
  // subtraction is enough to wrap the candidate index.
  always_comb begin
    int cand;
    cand    = 0;
    o_valid = 1'b0;
    o_idx   = 2'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(i_last_grant) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!o_valid && i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = 2'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharer of the UART controller's TX FIFO push port.
// Each requester posts a 16-bit value; the granted value is sent as the
// 7-byte ASCII frame  tag, hex3, hex2, hex1, hex0, CR, LF  where the tag is
// 'A' + requester index. Bytes are pushed one per cycle while the FIFO is
// not full, and the requester receives a one-cycle ack afterwards.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   req           per-requester request level, held until ack
//   req_data      requester i value in bits [16*i+15:16*i]
//   ack           one-cycle pulse when requester i's frame is fully pushed
//   tx_full       TX FIFO full flag
//   tx_push       push strobe to the TX FIFO
//   tx_push_data  byte pushed while tx_push is high
//   busy          high whenever the arbiter is not idle
//   grant_id      index of the current or most recent grantee
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLK_HZ  = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  input  logic                   tx_full,
  output logic                   tx_push,
  output logic [7:0]             tx_push_data,
  output logic                   busy,
  output logic [1:0]             grant_id
);

  // An out-of-range configuration never grants, rather than indexing
  // requesters that do not exist.
  localparam bit CFG_OK = (NUM_REQ >= 1) && (NUM_REQ <= 4) && (CLK_HZ > 0);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic [2:0]         r_byte_idx;
  logic [15:0]        r_frame;
  logic [1:0]         r_grant_id;
  logic [1:0]         r_last_grant;
  logic [NUM_REQ-1:0] r_ack;

  logic               w_pick_valid;
  logic [1:0]         w_pick_idx;
  logic               w_grant;
  logic               w_push;
  logic               w_last_byte;
  logic [15:0]        w_sel_data;
  logic [NUM_REQ-1:0] w_ack_onehot;
  logic [7:0]         w_byte;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_idx        (w_pick_idx)
  );

  assign w_sel_data   = req_data[int'(w_pick_idx)*16 +: 16];
  assign w_ack_onehot = NUM_REQ'(1) << r_grant_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. The push strobe is combinational on tx_full so a
  // full FIFO blocks the push in the same cycle; the byte index only moves
  // on an actual push, which is what guarantees no byte is lost or repeated.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_push       = 1'b0;
    w_last_byte  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid && CFG_OK) begin
          w_grant      = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          w_push = 1'b1;
          if (r_byte_idx == LAST_IDX) begin
            w_last_byte  = 1'b1;
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Data is captured at grant time, so requesters may change req_data or
  // drop req once granted. ack is raised on the edge that pushes the last
  // byte, which makes it visible exactly during the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_idx   <= 3'd0;
      r_frame      <= 16'h0000;
      r_grant_id   <= 2'd0;
      r_last_grant <= 2'(NUM_REQ - 1);
      r_ack        <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_frame    <= w_sel_data;
        r_grant_id <= w_pick_idx;
        r_byte_idx <= 3'd0;
      end
      if (w_push) begin
        if (w_last_byte) begin
          r_byte_idx <= 3'd0;
          r_ack      <= w_ack_onehot;
        end else begin
          r_byte_idx <= r_byte_idx + 3'd1;
        end
      end
      if (r_state == DONE) begin
        r_last_grant <= r_grant_id;
      end
    end
  end

  // Frame byte selection from registered sources only; the bus reads zero
  // outside SEND so nothing stale is presented to the FIFO.
  always_comb begin
    w_byte = 8'h00;
    if (r_state == SEND) begin
      case (r_byte_idx)
        3'd0:    w_byte = TAG_BASE + {6'b0, r_grant_id};
        3'd1:    w_byte = nib2hex(r_frame[15:12]);
        3'd2:    w_byte = nib2hex(r_frame[11:8]);
        3'd3:    w_byte = nib2hex(r_frame[7:4]);
        3'd4:    w_byte = nib2hex(r_frame[3:0]);
        3'd5:    w_byte = ASCII_CR;
        3'd6:    w_byte = ASCII_LF;
        default: w_byte = 8'h00;
      endcase
    end
  end

  assign tx_push      = w_push;
  assign tx_push_data = w_byte;
  assign busy         = (r_state != IDLE);
  assign grant_id     = r_grant_id;
  assign ack          = r_ack;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of frame records plus
// hand-written sequences for stalls, mid-frame request changes, reset in
// the middle of a frame and back-to-back frames from one requester.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack;
  logic        tx_full;
  logic        tx_push;
  logic [7:0]  tx_push_data;
  logic        busy;
  logic [1:0]  grant_id;

  int assertCount;
  int failCount;

  typedef struct {
    logic        doReset;
    logic [3:0]  req;
    logic [63:0] data;
    logic [1:0]  gid;
    logic [55:0] bytes;
    logic        last;
  } vec_t;

  vec_t tbl [11];

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .CLK_HZ  (100_000_000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .tx_full      (tx_full),
    .tx_push      (tx_push),
    .tx_push_data (tx_push_data),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a wedged DUT still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive inputs at a falling edge; the following rising edge consumes them.
  task automatic applyStimulus(input logic [3:0] r, input logic [63:0] d);
    @(negedge clk);
    req      = r;
    req_data = d;
    tx_full  = 1'b0;
    #1;
  endtask

  task automatic checkReset(input string nm);
    checkOutput({nm, "_ack"},  64'(ack), 64'h0);
    checkOutput({nm, "_push"}, 64'(tx_push), 64'h0);
    checkOutput({nm, "_data"}, 64'(tx_push_data), 64'h0);
    checkOutput({nm, "_busy"}, 64'(busy), 64'h0);
    checkOutput({nm, "_gid"},  64'(grant_id), 64'h0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst     = 1'b0;
    req     = '0;
    tx_full = 1'b0;
    #1;
    checkReset("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // Called right after the grant cycle. Follows the frame cycle by cycle,
  // optionally stalling with tx_full for 3 cycles in front of bytes
  // stallA/stallB, then checks the ack cycle and the idle cycle after it.
  task automatic checkFrame(input string nm, input logic [1:0] expGid,
                            input logic [55:0] expBytes, input int stallA,
                            input int stallB, input bit dropReq,
                            input bit lastFrame, input int expSpan);
    int k;
    int cyc;
    int firstPush;
    int lastPush;
    int stallCnt;
    logic [7:0] expByte;
    logic [3:0] expAck;
    k = 0; cyc = 0; firstPush = -1; lastPush = -1; stallCnt = 0;
    expAck = 4'b0001 << expGid;
    while (k < 7 && cyc < 40) begin
      @(negedge clk);
      if (dropReq) begin
        req      = '0;
        req_data = '1;
      end
      if ((k == stallA || k == stallB) && stallCnt < 3) begin
        tx_full = 1'b1;
        stallCnt++;
      end else begin
        tx_full = 1'b0;
      end
      #1;
      checkOutput({nm, "_busy"}, 64'(busy), 64'h1);
      if (tx_full) begin
        checkOutput($sformatf("%s_stall_b%0d", nm, k), 64'(tx_push), 64'h0);
      end else begin
        checkOutput($sformatf("%s_push_b%0d", nm, k), 64'(tx_push), 64'h1);
        if (tx_push) begin
          expByte = expBytes[8*(6-k) +: 8];
          checkOutput($sformatf("%s_byte%0d", nm, k), 64'(tx_push_data), 64'(expByte));
          if (k == 0) begin
            firstPush = cyc;
            checkOutput({nm, "_gid"}, 64'(grant_id), 64'(expGid));
          end
          lastPush = cyc;
          k++;
          stallCnt = 0;
        end
      end
      cyc++;
    end
    if (k < 7) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s_timeout: got %0d bytes, expected 7", nm, k);
    end
    checkOutput({nm, "_first_push"}, 64'(firstPush), 64'h0);
    checkOutput({nm, "_span"}, 64'(lastPush - firstPush), 64'(expSpan));
    @(negedge clk);
    tx_full = 1'b0;
    if (lastFrame) req = '0;
    #1;
    checkOutput({nm, "_ack"}, 64'(ack), 64'(expAck));
    checkOutput({nm, "_ack_push"}, 64'(tx_push), 64'h0);
    checkOutput({nm, "_ack_busy"}, 64'(busy), 64'h1);
    @(negedge clk);
    #1;
    checkOutput({nm, "_ack_clear"}, 64'(ack), 64'h0);
    checkOutput({nm, "_idle_busy"}, 64'(busy), 64'h0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst      = 1'b0;
    req      = '0;
    req_data = '0;
    tx_full  = 1'b0;

    //                doRst  req      data                     gid   bytes                     last
    tbl[0]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_12AF, 2'd0, 56'h41_31_32_41_46_0D_0A, 1'b1};
    tbl[1]  = '{1'b1, 4'b1111, 64'h3333_2222_1111_0000, 2'd0, 56'h41_30_30_30_30_0D_0A, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 64'h3333_2222_1111_0000, 2'd1, 56'h42_31_31_31_31_0D_0A, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 64'h3333_2222_1111_0000, 2'd2, 56'h43_32_32_32_32_0D_0A, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 64'h3333_2222_1111_0000, 2'd3, 56'h44_33_33_33_33_0D_0A, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 64'h3333_2222_1111_0000, 2'd0, 56'h41_30_30_30_30_0D_0A, 1'b1};
    tbl[6]  = '{1'b0, 4'b1000, 64'h9C05_0000_0000_0000, 2'd3, 56'h44_39_43_30_35_0D_0A, 1'b1};
    tbl[7]  = '{1'b0, 4'b0110, 64'h0000_7E30_ABCD_0000, 2'd1, 56'h42_41_42_43_44_0D_0A, 1'b0};
    tbl[8]  = '{1'b0, 4'b0110, 64'h0000_7E30_ABCD_0000, 2'd2, 56'h43_37_45_33_30_0D_0A, 1'b1};
    tbl[9]  = '{1'b0, 4'b0101, 64'h0000_5A5A_0000_F00F, 2'd0, 56'h41_46_30_30_46_0D_0A, 1'b0};
    tbl[10] = '{1'b0, 4'b0101, 64'h0000_5A5A_0000_F00F, 2'd2, 56'h43_35_41_35_41_0D_0A, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    checkReset("por");
    @(negedge clk);
    rst = 1'b1;

    // Table: a new request is applied only where the previous record
    // released req; otherwise the held request is re-granted in the idle
    // cycle that follows the ack.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].doReset) applyReset();
      if (i == 0 || tbl[i-1].last) begin
        applyStimulus(tbl[i].req, tbl[i].data);
        checkOutput($sformatf("vec%0d_grant_busy", i), 64'(busy), 64'h0);
      end
      checkFrame($sformatf("vec%0d", i), tbl[i].gid, tbl[i].bytes, -1, -1, 1'b0, tbl[i].last, 6);
    end

    // tx_full for 3 cycles in front of byte 2 and byte 6.
    applyStimulus(4'b0010, 64'h0000_0000_12AF_0000);
    checkFrame("stall", 2'd1, 56'h42_31_32_41_46_0D_0A, 2, 6, 1'b0, 1'b1, 12);

    // Request dropped and data trashed right after the grant.
    applyStimulus(4'b0100, 64'h0000_6B1D_0000_0000);
    checkFrame("drop", 2'd2, 56'h43_36_42_31_44_0D_0A, -1, -1, 1'b1, 1'b1, 6);
    @(negedge clk);
    #1;
    checkOutput("drop_no_regrant", 64'(busy), 64'h0);

    // Reset while byte 3 is due.
    applyStimulus(4'b1000, 64'h0042_0000_0000_0000);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rstmid_push%0d", b), 64'(tx_push), 64'h1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkReset("rstmid");
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("rstmid_no_ack", 64'(ack), 64'h0);
    end
    @(negedge clk);
    rst      = 1'b1;
    req      = 4'b1001;
    req_data = 64'hAAAA_0000_0000_3C7E;
    #1;
    checkFrame("rstmid_fresh", 2'd0, 56'h41_33_43_37_45_0D_0A, -1, -1, 1'b0, 1'b1, 6);

    // One requester holding req: back-to-back frames, 9-cycle period.
    applyStimulus(4'b0010, 64'h0000_0000_0F1E_0000);
    checkFrame("b2b_0", 2'd1, 56'h42_30_46_31_45_0D_0A, -1, -1, 1'b0, 1'b0, 6);
    checkFrame("b2b_1", 2'd1, 56'h42_30_46_31_45_0D_0A, -1, -1, 1'b0, 1'b1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
